// File: rtl/rv32_mc_ctrl.sv
// Multicycle RV32I control FSM: decodes IR and sequences fetch/decode/execute/memory/writeback.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready; R/I/jal 4 cycles, beq/bne 3, sw 4, lw 5.
module rv32_mc_ctrl #(
  parameter bit RESET_TRAP = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_control,
  output logic [1:0]  result_src,
  output logic [1:0]  imm_src,
  output logic        trap,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  state_t      state, next_state;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [2:0]  exec_ctl;
  logic        exec_ok;
  logic        branch_ok;
  logic        mem_req_c, mem_we_c, ir_write_c, pc_write_c, reg_write_c;
  logic        unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign funct7_5          = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};
  assign branch_ok         = (funct3[2:1] == 2'b00);

  always_comb begin
    exec_ctl = ALU_ADD;
    exec_ok  = 1'b1;
    case (funct3)
      3'b000: exec_ctl = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b111: exec_ctl = ALU_AND;
      3'b110: exec_ctl = ALU_OR;
      3'b100: exec_ctl = ALU_XOR;
      3'b010: exec_ctl = ALU_SLT;
      3'b001: exec_ctl = ALU_SLL;
      3'b101: begin
        exec_ctl = ALU_SRL;
        exec_ok  = ~funct7_5;  // arithmetic shifts are not supported by this ALU
      end
      default: exec_ok = 1'b0;
    endcase
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECR;
          OP_I:              next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          default:           next_state = S_TRAP;
        endcase
      end
      S_MEMADR: next_state = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECR,
      S_EXECI:  next_state = exec_ok ? S_ALUWB : S_TRAP;
      S_ALUWB:  next_state = S_FETCH;
      S_BRANCH: next_state = branch_ok ? S_FETCH : S_TRAP;
      S_JAL:    next_state = S_ALUWB;
      S_TRAP:   next_state = RESET_TRAP ? S_TRAP : S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      trap  <= 1'b0;
    end else begin
      state <= next_state;
      if (RESET_TRAP && next_state == S_TRAP)
        trap <= 1'b1;
    end
  end

  always_comb begin
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    adr_src     = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    result_src  = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        adr_src   = 1'b1;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
      end
      S_MEMWR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = exec_ctl;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = exec_ctl;
      end
      S_ALUWB:  reg_write_c = 1'b1;
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write_c  = branch_ok & (zero ^ funct3[0]);
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset abandons any in-flight access: nothing is requested or written that cycle.
  assign mem_req   = mem_req_c   & ~rst;
  assign mem_we    = mem_we_c    & ~rst;
  assign ir_write  = ir_write_c  & ~rst;
  assign pc_write  = pc_write_c  & ~rst;
  assign reg_write = reg_write_c & ~rst;

  always_comb begin
    case (opcode)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_rv32_mc_ctrl.sv
// Directed bench for rv32_mc_ctrl; a trapping and a non-trapping instance share stimulus.
module tb_rv32_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;

  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, trap;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_dbg;

  logic       n_mem_req, n_mem_we, n_adr_src, n_ir_write, n_pc_write, n_reg_write, n_trap;
  logic [1:0] n_alu_src_a, n_alu_src_b, n_result_src, n_imm_src;
  logic [2:0] n_alu_control;
  logic [3:0] n_state_dbg;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                         MEMWB = 4'd4, MEMWR = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
                         ALUWB = 4'd8, BRANCH = 4'd9, JAL = 4'd10, TRAP = 4'd11;

  always #5 clk = ~clk;

  rv32_mc_ctrl #(.RESET_TRAP(1'b1)) u_dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .result_src(result_src),
    .imm_src(imm_src), .trap(trap), .state_dbg(state_dbg)
  );

  rv32_mc_ctrl #(.RESET_TRAP(1'b0)) u_dut_nt (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(n_mem_req), .mem_we(n_mem_we), .adr_src(n_adr_src), .ir_write(n_ir_write),
    .pc_write(n_pc_write), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a),
    .alu_src_b(n_alu_src_b), .alu_control(n_alu_control), .result_src(n_result_src),
    .imm_src(n_imm_src), .trap(n_trap), .state_dbg(n_state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next low phase, apply inputs, let combinational outputs settle.
  task automatic step(input logic mr, input logic z);
    @(negedge clk);
    mem_ready = mr;
    zero      = z;
    #1;
  endtask

  // Issue instruction from FETCH with an immediate memory response, then land in DECODE.
  task automatic fetch_decode(input logic [31:0] ins, input string tag);
    instr     = ins;
    mem_ready = 1'b1;
    #1;
    check({tag, " fetch state"}, state_dbg, FETCH);
    check({tag, " fetch ir_write"}, ir_write, 1'b1);
    check({tag, " fetch pc_write"}, pc_write, 1'b1);
    step(1'b0, 1'b0);
    check({tag, " decode state"}, state_dbg, DECODE);
  endtask

  initial begin
    rst = 1'b1; instr = 32'h0000_0013; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst ir_write gated", ir_write, 1'b0);
    check("rst pc_write gated", pc_write, 1'b0);
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    check("reset state", state_dbg, FETCH);
    check("reset trap", trap, 1'b0);
    check("reset mem_req", mem_req, 1'b1);
    check("reset reg_write", reg_write, 1'b0);
    check("reset pc_write", pc_write, 1'b0);
    check("fetch stall ir_write", ir_write, 1'b0);
    check("fetch alu_src_b", alu_src_b, 2'b10);
    check("fetch result_src", result_src, 2'b10);
    step(1'b0, 1'b0);
    check("fetch stall state", state_dbg, FETCH);

    // add x3,x1,x2
    fetch_decode(32'h0020_81B3, "add");
    check("add decode src_a", alu_src_a, 2'b01);
    check("add decode src_b", alu_src_b, 2'b01);
    step(1'b0, 1'b0);
    check("add execr state", state_dbg, EXECR);
    check("add alu_control", alu_control, 3'b000);
    check("add alu_src_b", alu_src_b, 2'b00);
    check("add alu_src_a", alu_src_a, 2'b10);
    step(1'b0, 1'b0);
    check("add aluwb state", state_dbg, ALUWB);
    check("add reg_write", reg_write, 1'b1);
    check("add result_src", result_src, 2'b00);
    step(1'b0, 1'b0);
    check("add back to fetch", state_dbg, FETCH);

    // sub x3,x1,x2
    fetch_decode(32'h4020_81B3, "sub");
    step(1'b0, 1'b0);
    check("sub alu_control", alu_control, 3'b001);
    step(1'b0, 1'b0);
    check("sub aluwb state", state_dbg, ALUWB);
    step(1'b0, 1'b0);

    // addi x1,x0,5
    fetch_decode(32'h0050_0093, "addi");
    check("addi imm_src", imm_src, 2'b00);
    step(1'b0, 1'b0);
    check("addi execi state", state_dbg, EXECI);
    check("addi alu_control", alu_control, 3'b000);
    check("addi alu_src_b", alu_src_b, 2'b01);
    step(1'b0, 1'b0);
    check("addi reg_write", reg_write, 1'b1);
    step(1'b0, 1'b0);

    // lw x5,0(x1) with three wait cycles in MEMRD
    fetch_decode(32'h0000_A283, "lw");
    step(1'b0, 1'b0);
    check("lw memadr state", state_dbg, MEMADR);
    check("lw memadr src_a", alu_src_a, 2'b10);
    check("lw memadr src_b", alu_src_b, 2'b01);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, 1'b0);
      check("lw memrd state", state_dbg, MEMRD);
      check("lw mem_req held", mem_req, 1'b1);
      check("lw adr_src", adr_src, 1'b1);
      check("lw no reg_write", reg_write, 1'b0);
    end
    step(1'b0, 1'b0);
    check("lw memwb state", state_dbg, MEMWB);
    check("lw result_src", result_src, 2'b01);
    check("lw reg_write", reg_write, 1'b1);
    step(1'b0, 1'b0);
    check("lw back to fetch", state_dbg, FETCH);

    // sw x2,0(x1)
    fetch_decode(32'h0020_A023, "sw");
    check("sw imm_src", imm_src, 2'b01);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("sw memwr state", state_dbg, MEMWR);
    check("sw mem_we", mem_we, 1'b1);
    check("sw mem_req", mem_req, 1'b1);
    step(1'b0, 1'b0);
    check("sw back to fetch", state_dbg, FETCH);

    // beq taken / not taken, bne taken
    fetch_decode(32'h0020_8463, "beq1");
    check("beq imm_src", imm_src, 2'b10);
    step(1'b0, 1'b1);
    check("beq branch state", state_dbg, BRANCH);
    check("beq alu_control", alu_control, 3'b001);
    check("beq zero=1 pc_write", pc_write, 1'b1);
    step(1'b0, 1'b0);
    check("beq back to fetch", state_dbg, FETCH);
    fetch_decode(32'h0020_8463, "beq0");
    step(1'b1, 1'b0);
    check("beq zero=0 pc_write", pc_write, 1'b0);
    step(1'b0, 1'b0);
    fetch_decode(32'h0020_9463, "bne");
    step(1'b0, 1'b0);
    check("bne zero=0 pc_write", pc_write, 1'b1);
    step(1'b0, 1'b0);

    // jal x0,0
    fetch_decode(32'h0000_006F, "jal");
    check("jal imm_src", imm_src, 2'b11);
    step(1'b0, 1'b0);
    check("jal state", state_dbg, JAL);
    check("jal pc_write", pc_write, 1'b1);
    check("jal src_a", alu_src_a, 2'b01);
    check("jal src_b", alu_src_b, 2'b10);
    step(1'b0, 1'b0);
    check("jal aluwb reg_write", reg_write, 1'b1);
    step(1'b0, 1'b0);

    // illegal opcode
    fetch_decode(32'h0000_007F, "ill");
    step(1'b0, 1'b0);
    check("ill trap state", state_dbg, TRAP);
    check("ill trap flag", trap, 1'b1);
    check("ill no mem_req", mem_req, 1'b0);
    check("ill no reg_write", reg_write, 1'b0);
    check("nt trap state", n_state_dbg, TRAP);
    check("nt trap flag", n_trap, 1'b0);
    step(1'b1, 1'b0);
    check("trap sticky state", state_dbg, TRAP);
    check("trap sticky flag", trap, 1'b1);
    check("trap no pc_write", pc_write, 1'b0);
    check("trap no ir_write", ir_write, 1'b0);
    check("nt back to fetch", n_state_dbg, FETCH);
    check("nt trap still 0", n_trap, 1'b0);
    mem_ready = 1'b0;
    step(1'b0, 1'b0);
    check("trap held", state_dbg, TRAP);

    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("post-trap reset state", state_dbg, FETCH);
    check("post-trap reset flag", trap, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
